den_giao_thong: RTL and testbench

//   Single-direction traffic-light controller with a two-digit countdown display.

---
 rtl/den_giao_thong.sv | 105 ++++++++++
 tb/tb_den_giao_thong.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/den_giao_thong.sv
// Single-direction traffic light: RED -> GREEN -> YELLOW -> RED, each phase a
// programmable number of seconds, with the seconds remaining shown on two 7-segment digits.
module den_giao_thong #(
  parameter int TICK_DIV    = 40_000_000,
  parameter int RED_TIME    = 30,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5
) (
  input  logic       clock,
  input  logic       reset,
  output logic       ledRed,
  output logic       ledGreen,
  output logic       ledYellow,
  output logic [6:0] led7Seg1,
  output logic [6:0] led7Seg0
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [6:0]      RED_CNT    = 7'(RED_TIME);
  localparam logic [6:0]      GREEN_CNT  = 7'(GREEN_TIME);
  localparam logic [6:0]      YELLOW_CNT = 7'(YELLOW_TIME);

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [6:0]    next_len;
  logic [6:0]    cnt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    tens;
  logic [3:0]    units;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (presc == PRESC_MAX);

  always_comb begin
    next_state = RED;
    next_len   = RED_CNT;
    case (state)
      RED:     begin next_state = GREEN;  next_len = GREEN_CNT;  end
      GREEN:   begin next_state = YELLOW; next_len = YELLOW_CNT; end
      YELLOW:  begin next_state = RED;    next_len = RED_CNT;    end
      default: begin next_state = RED;    next_len = RED_CNT;    end
    endcase
  end

  // The phase length is loaded when the count would reach 0, so the display never shows 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      state <= RED;
      cnt   <= RED_CNT;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        RED, GREEN, YELLOW: begin
          if (tick) begin
            if (cnt > 7'd1) begin
              cnt <= cnt - 7'd1;
            end else begin
              state <= next_state;
              cnt   <= next_len;
            end
          end
        end
        default: begin
          state <= RED;
          cnt   <= RED_CNT;
        end
      endcase
    end
  end

  assign ledRed    = (state == RED);
  assign ledGreen  = (state == GREEN);
  assign ledYellow = (state == YELLOW);

  assign tens     = 4'(cnt / 7'd10);
  assign units    = 4'(cnt % 7'd10);
  assign led7Seg1 = seg7(tens);
  assign led7Seg0 = seg7(units);

endmodule

// File: tb/tb_den_giao_thong.sv
// Directed bench for den_giao_thong with a 4-clock second: reset, phase sequence,
// asynchronous mid-phase reset and per-cycle one-hot/display checks over three periods.
module tb_den_giao_thong;

  logic       clock;
  logic       reset;
  logic       ledRed;
  logic       ledGreen;
  logic       ledYellow;
  logic [6:0] led7Seg1;
  logic [6:0] led7Seg0;
  logic [2:0]  lamps;
  logic [13:0] disp;

  int n_checks = 0;
  int n_fail   = 0;

  den_giao_thong #(
    .TICK_DIV(4),
    .RED_TIME(30),
    .GREEN_TIME(25),
    .YELLOW_TIME(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ledRed(ledRed),
    .ledGreen(ledGreen),
    .ledYellow(ledYellow),
    .led7Seg1(led7Seg1),
    .led7Seg0(led7Seg0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign lamps = {ledRed, ledGreen, ledYellow};
  assign disp  = {led7Seg1, led7Seg0};

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int seg_to_digit(input logic [6:0] s);
    case (s)
      7'h40: seg_to_digit = 0;
      7'h79: seg_to_digit = 1;
      7'h24: seg_to_digit = 2;
      7'h30: seg_to_digit = 3;
      7'h19: seg_to_digit = 4;
      7'h12: seg_to_digit = 5;
      7'h02: seg_to_digit = 6;
      7'h78: seg_to_digit = 7;
      7'h00: seg_to_digit = 8;
      7'h10: seg_to_digit = 9;
      default: seg_to_digit = -1;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run(1);
      n_checks++;
      if (lamps !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_lamps[%0d]: got %b want 100", i, lamps);
      end
      n_checks++;
      if (disp !== {7'h30, 7'h40}) begin
        n_fail++;
        $display("FAIL reset_display[%0d]: got %h want %h", i, disp, {7'h30, 7'h40});
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_first_tick();
    run(3);
    n_checks++;
    if (disp !== {7'h30, 7'h40}) begin
      n_fail++;
      $display("FAIL before_first_tick: got %h want %h", disp, {7'h30, 7'h40});
    end
    run(1);
    n_checks++;
    if (disp !== {7'h24, 7'h10}) begin
      n_fail++;
      $display("FAIL first_tick_29: got %h want %h", disp, {7'h24, 7'h10});
    end
    n_checks++;
    if (lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL first_tick_red: got %b want 100", lamps);
    end
  endtask

  task automatic test_phase_sequence();
    run(115);  // 119 clocks since release
    n_checks++;
    if (disp !== {7'h40, 7'h79} || lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL red_last_second: got %b/%h want 100/%h", lamps, disp, {7'h40, 7'h79});
    end
    run(1);
    n_checks++;
    if (disp !== {7'h24, 7'h12} || lamps !== 3'b010) begin
      n_fail++;
      $display("FAIL green_entry: got %b/%h want 010/%h", lamps, disp, {7'h24, 7'h12});
    end
    run(99);
    n_checks++;
    if (disp !== {7'h40, 7'h79} || lamps !== 3'b010) begin
      n_fail++;
      $display("FAIL green_last_second: got %b/%h want 010/%h", lamps, disp, {7'h40, 7'h79});
    end
    run(1);
    n_checks++;
    if (disp !== {7'h40, 7'h12} || lamps !== 3'b001) begin
      n_fail++;
      $display("FAIL yellow_entry: got %b/%h want 001/%h", lamps, disp, {7'h40, 7'h12});
    end
    run(19);
    n_checks++;
    if (disp !== {7'h40, 7'h79} || lamps !== 3'b001) begin
      n_fail++;
      $display("FAIL yellow_last_second: got %b/%h want 001/%h", lamps, disp, {7'h40, 7'h79});
    end
    run(1);
    n_checks++;
    if (disp !== {7'h30, 7'h40} || lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL red_reentry: got %b/%h want 100/%h", lamps, disp, {7'h30, 7'h40});
    end
  endtask

  task automatic test_async_reset();
    run(130);  // 120 clocks to GREEN, 10 more: two ticks -> 23
    n_checks++;
    if (disp !== {7'h24, 7'h30} || lamps !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_green_23: got %b/%h want 010/%h", lamps, disp, {7'h24, 7'h30});
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (disp !== {7'h30, 7'h40} || lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b/%h want 100/%h", lamps, disp, {7'h30, 7'h40});
    end
    run(2);
    n_checks++;
    if (disp !== {7'h30, 7'h40} || lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset_held: got %b/%h want 100/%h", lamps, disp, {7'h30, 7'h40});
    end
    @(negedge clock);
    reset = 1'b1;
    run(119);
    n_checks++;
    if (disp !== {7'h40, 7'h79} || lamps !== 3'b100) begin
      n_fail++;
      $display("FAIL after_reset_red_full: got %b/%h want 100/%h", lamps, disp, {7'h40, 7'h79});
    end
    run(1);
    n_checks++;
    if (disp !== {7'h24, 7'h12} || lamps !== 3'b010) begin
      n_fail++;
      $display("FAIL after_reset_green: got %b/%h want 010/%h", lamps, disp, {7'h24, 7'h12});
    end
  endtask

  // Starts just after GREEN was entered (prescaler at 0); follows an independent phase model.
  task automatic test_invariants();
    int m_state;  // 0 red, 1 green, 2 yellow
    int m_cnt;
    int m_presc;
    int shown;
    int t;
    int u;
    logic [2:0] want_lamps;
    m_state = 1;
    m_cnt   = 25;
    m_presc = 0;
    for (int c = 0; c < 720; c++) begin
      run(1);
      if (m_presc == 3) begin
        m_presc = 0;
        if (m_cnt > 1) m_cnt--;
        else begin
          m_state = (m_state + 1) % 3;
          m_cnt   = (m_state == 0) ? 30 : (m_state == 1) ? 25 : 5;
        end
      end else begin
        m_presc++;
      end
      t = seg_to_digit(led7Seg1);
      u = seg_to_digit(led7Seg0);
      shown = (t < 0 || u < 0) ? -1 : t * 10 + u;
      n_checks++;
      if (!$onehot(lamps)) begin
        n_fail++;
        $display("FAIL onehot[%0d]: got %b want exactly one lamp", c, lamps);
      end
      n_checks++;
      if (shown < 1 || shown > 99) begin
        n_fail++;
        $display("FAIL display_range[%0d]: got %0d (%h) want 1..99", c, shown, disp);
      end
      want_lamps = (m_state == 0) ? 3'b100 : (m_state == 1) ? 3'b010 : 3'b001;
      n_checks++;
      if (lamps !== want_lamps || shown != m_cnt) begin
        n_fail++;
        $display("FAIL model[%0d]: got %b/%0d want %b/%0d", c, lamps, shown, want_lamps, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_first_tick();
    test_phase_sequence();
    test_async_reset();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
